// File: rtl/sig_dump_pkg.sv
// Shared types and default constants for the signature dump block.
package sig_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RD    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_FIN   = 3'd5
    } sig_dump_state_e;

    localparam logic [15:0] DEF_BEGIN_PTR = 16'h3FF0;
    localparam logic [15:0] DEF_END_PTR   = 16'h3FF4;
    localparam logic [31:0] DEF_MIN_BEGIN = 32'd16;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sig_dump.sv
// Snoops begin/end signature pointers off the store bus, then streams the
// RAM words in [begin, end) out over a valid/ready port.
//
// state  | meaning
// IDLE   | snooping for begin/end pointer writes
// CHECK  | evaluating captured range
// RD     | one-cycle RAM read request for cur_addr
// WAIT   | RAM data returning, captured into out_data
// SEND   | word presented, waiting for out_ready
// FIN    | dump complete or range rejected; parked until reset
module sig_dump
    import sig_dump_pkg::*;
#(
    parameter logic [15:0] BEGIN_PTR = DEF_BEGIN_PTR,
    parameter logic [15:0] END_PTR   = DEF_END_PTR,
    parameter logic [31:0] MIN_BEGIN = DEF_MIN_BEGIN
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        snp_wr_en,
    input  logic [15:0] snp_wr_addr,
    input  logic [31:0] snp_wr_data,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    sig_dump_state_e state, state_nxt;
    logic [31:0] begin_q, end_q, cur_addr, cur_addr_nxt;
    logic        range_ok, last_word, xfer;

    // begin_q is stored word-aligned; end_q stays raw so a partial final
    // word still counts toward the dump length.
    assign range_ok  = (word_align(end_q) > begin_q) && (begin_q > MIN_BEGIN);
    assign last_word = ({1'b0, cur_addr} + 33'd4) >= {1'b0, end_q};
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        cur_addr_nxt = cur_addr;
        case (state)
            ST_IDLE: begin
                if (snp_wr_en && (snp_wr_addr == END_PTR))
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (range_ok) begin
                    state_nxt    = ST_RD;
                    cur_addr_nxt = begin_q;
                end else begin
                    state_nxt = ST_FIN;
                end
            end
            ST_RD:   state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_SEND;
            ST_SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt    = ST_RD;
                        cur_addr_nxt = cur_addr + 32'd4;
                    end
                end
            end
            ST_FIN:  state_nxt = ST_FIN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ST_IDLE;
            begin_q     <= '0;
            end_q       <= '0;
            cur_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_addr <= cur_addr_nxt;

            if ((state == ST_IDLE) && snp_wr_en) begin
                if (snp_wr_addr == BEGIN_PTR)
                    begin_q <= word_align(snp_wr_data);
                if (snp_wr_addr == END_PTR)
                    end_q <= snp_wr_data;
            end

            // Outputs are registered off the next state so they line up
            // exactly with the state they belong to.
            mem_rd_en <= (state_nxt == ST_RD);
            if (state_nxt == ST_RD)
                mem_rd_addr <= cur_addr_nxt;

            busy      <= state_nxt inside {ST_CHECK, ST_RD, ST_WAIT, ST_SEND};
            out_valid <= (state_nxt == ST_SEND);

            if (state == ST_WAIT) begin
                out_data <= mem_rd_data;
                out_last <= last_word;
            end else if (state_nxt != ST_SEND) begin
                out_last <= 1'b0;
            end

            if ((state == ST_CHECK) && !range_ok)
                err <= 1'b1;
            if ((state == ST_SEND) && xfer && out_last)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sig_dump.sv
// Self-checking bench for sig_dump: directed range table, hand-written
// reset/ignore sequences and randomized ranges against a word-list model.
module tb_sig_dump;

    localparam logic [15:0] BPTR = 16'h3FF0;
    localparam logic [15:0] EPTR = 16'h3FF4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        snp_wr_en = 1'b0;
    logic [15:0] snp_wr_addr = '0;
    logic [31:0] snp_wr_data = '0;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    int          rd_pulses;

    sig_dump dut (
        .clk(clk), .rst_b(rst_b),
        .snp_wr_en(snp_wr_en), .snp_wr_addr(snp_wr_addr), .snp_wr_data(snp_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h2000: return 32'h11;
            32'h2004: return 32'h22;
            32'h2008: return 32'h33;
            32'h200C: return 32'h44;
            default:  return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    // RAM answers one cycle after the request
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram_word(mem_rd_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: range validity and word count from the plain rules.
    function automatic bit model_valid(input logic [31:0] b, input logic [31:0] e);
        return ((e & ~32'd3) > (b & ~32'd3)) && ((b & ~32'd3) > 32'd16);
    endfunction

    function automatic int model_words(input logic [31:0] b, input logic [31:0] e);
        if (!model_valid(b, e)) return 0;
        return int'((e - (b & ~32'd3) + 32'd3) >> 2);
    endfunction

    task automatic snoop_write(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        snp_wr_en = 1'b1; snp_wr_addr = a; snp_wr_data = d;
        @(posedge clk); #1;
        snp_wr_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        check(name, {31'd0, mem_rd_en, mem_rd_addr}, 64'd0);
        check({name, ".out"}, {27'd0, out_valid, out_data, out_last, busy, done, err}, 64'd0);
    endtask

    task automatic do_reset(input string name);
        #1 rst_b = 1'b0;
        #2 check_zero_outputs(name);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_b = 1'b1;
    endtask

    // Runs the dump after the end-pointer write, recording transfers.
    // mode 0: ready always high, 1: ready 1-of-3 cycles, 2: random ready.
    task automatic collect(input logic [31:0] base, input int mode, input int abort_after,
                           input int budget, input bit poke, output bit timed_out);
        int cyc = 0;
        int last_xfer = -1;
        bit prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic prev_last = 0;
        got_data.delete(); got_last.delete(); rd_pulses = 0;
        timed_out = 1;
        if (poke) begin
            snp_wr_en = 1'b1; snp_wr_addr = BPTR; snp_wr_data = 32'h5000;
        end
        while (cyc < budget) begin
            @(posedge clk); #1;
            snp_wr_en = 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (prev_stall)
                check("hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (out_valid) check("busy_when_valid", busy, 1);
            if (mem_rd_en) begin
                check("rd_addr", mem_rd_addr, base + 32'(rd_pulses) * 4);
                rd_pulses++;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (mode == 0 && last_xfer >= 0) check("throughput", cyc - last_xfer, 3);
                last_xfer = cyc;
                if (abort_after > 0 && got_data.size() == abort_after) begin
                    timed_out = 0;
                    return;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done || err) begin
                timed_out = 0;
                break;
            end
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] b, input logic [31:0] e,
                                input bit exp_err, input int exp_n, input bit timed_out);
        logic [31:0] bal = b & ~32'd3;
        check({name, ".timeout"}, timed_out, 0);
        check({name, ".err"}, err, exp_err);
        check({name, ".done"}, done, !exp_err);
        check({name, ".busy"}, busy, 0);
        check({name, ".nwords"}, got_data.size(), exp_n);
        check({name, ".rd_pulses"}, rd_pulses, exp_n);
        for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
            check($sformatf("%s.data%0d", name, i), got_data[i], ram_word(bal + 32'(i) * 4));
            check($sformatf("%s.last%0d", name, i), got_last[i], i == exp_n - 1);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] b;
        logic [31:0] e;
        int          mode;
        bit          exp_err;
        int          exp_n;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit to;
        vecs[0] = '{"basic4",     32'h2000, 32'h2010, 0, 0, 4};
        vecs[1] = '{"slowready",  32'h2000, 32'h2010, 1, 0, 4};
        vecs[2] = '{"lowbegin",   32'h10,   32'h20,   0, 1, 0};
        vecs[3] = '{"emptyrange", 32'h3000, 32'h3000, 0, 1, 0};
        vecs[4] = '{"partial",    32'h2000, 32'h2006, 0, 0, 2};
        vecs[5] = '{"minbegin",   32'h14,   32'h18,   2, 0, 1};
        vecs[6] = '{"unaligned",  32'h2003, 32'h2004, 0, 0, 1};
        vecs[7] = '{"subword",    32'h2000, 32'h2002, 0, 1, 0};
        vecs[8] = '{"backwards",  32'h2010, 32'h2000, 2, 1, 0};

        #2 rst_b = 1'b0;
        #2 check_zero_outputs("reset0");
        @(posedge clk); @(negedge clk) rst_b = 1'b1;

        foreach (vecs[k]) begin
            snoop_write(BPTR, vecs[k].b);
            snoop_write(EPTR, vecs[k].e);
            collect(vecs[k].b & ~32'd3, vecs[k].mode, 0, 200, 0, to);
            check_result(vecs[k].name, vecs[k].b, vecs[k].e, vecs[k].exp_err, vecs[k].exp_n, to);
            do_reset({vecs[k].name, ".rst"});
        end

        // begin write arriving after the end write must not disturb the dump
        snoop_write(BPTR, 32'h2000);
        snoop_write(EPTR, 32'h2010);
        collect(32'h2000, 0, 0, 200, 1, to);
        check_result("latebegin", 32'h2000, 32'h2010, 0, 4, to);

        // snoop writes after FIN are ignored
        snoop_write(BPTR, 32'h2000);
        snoop_write(EPTR, 32'h2010);
        rd_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd_en) rd_pulses++;
            check("fin.busy", busy, 0);
        end
        check("fin.rd_pulses", rd_pulses, 0);
        check("fin.done", done, 1);
        do_reset("fin.rst");

        // reset after the second word, then restart from word 0
        snoop_write(BPTR, 32'h2000);
        snoop_write(EPTR, 32'h2010);
        collect(32'h2000, 0, 2, 200, 0, to);
        check("abort.timeout", to, 0);
        check("abort.nwords", got_data.size(), 2);
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1 check_zero_outputs("abort.async");
        @(posedge clk); @(negedge clk) rst_b = 1'b1;
        snoop_write(BPTR, 32'h2000);
        snoop_write(EPTR, 32'h2010);
        collect(32'h2000, 0, 0, 200, 0, to);
        check_result("restart", 32'h2000, 32'h2010, 0, 4, to);
        do_reset("restart.rst");

        // randomized ranges, random backpressure
        for (int r = 0; r < 20; r++) begin
            logic [31:0] b, e;
            int n;
            if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 40));
            else b = 32'h1000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            e = b + 32'($urandom_range(0, 40));
            n = model_words(b, e);
            snoop_write(BPTR, b);
            snoop_write(EPTR, e);
            collect(b & ~32'd3, 2, 0, 50 + 20 * n, 0, to);
            check_result($sformatf("rand%0d", r), b, e, !model_valid(b, e), n, to);
            do_reset($sformatf("rand%0d.rst", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
